// File: rtl/mpc_pkg.sv
// mpc_pkg: shared constants, arbiter state type and the header-to-block
// helper used by the per-port write arbiter.
//   PORTNUM       number of input channels feeding one port
//   HDR_LEN_*     bit range of the packet length field in the header word
//   BLOCK_SHIFT   log2 of the RAM block size in bytes (64-byte blocks)
//   HDR_OVERHEAD  bytes added to LEN before rounding up to whole blocks
package mpc_pkg;

    localparam int PORTNUM      = 16;
    localparam int HDR_LEN_MSB  = 16;
    localparam int HDR_LEN_LSB  = 7;
    localparam int BLOCK_SHIFT  = 6;
    localparam int HDR_OVERHEAD = 5;

    localparam int HDR_LEN_W = HDR_LEN_MSB - HDR_LEN_LSB + 1;
    localparam int BLK_SUM_W = HDR_LEN_W + 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_BUSY  = 2'd2
    } arb_state_e;

    // ceil((len + HDR_OVERHEAD) / 64): add (block size - 1) then shift.
    function automatic logic [HDR_LEN_W:0] blocks_needed(input logic [HDR_LEN_W-1:0] len);
        logic [BLK_SUM_W-1:0] sum;
        sum = {2'b00, len} + BLK_SUM_W'(HDR_OVERHEAD + (1 << BLOCK_SHIFT) - 1);
        return (HDR_LEN_W + 1)'(sum >> BLOCK_SHIFT);
    endfunction

endpackage

// File: rtl/rr_arb16.sv
// rr_arb16: combinational 16-way round-robin pick.
//   req_i  request vector
//   ptr_i  highest-priority index; priority falls off as the index wraps 15->0
//   gnt_o  one-hot winner (zero when no request)
//   idx_o  binary winner index
//   vld_o  at least one request present
module rr_arb16 (
    input  logic [15:0] req_i,
    input  logic [3:0]  ptr_i,
    output logic [15:0] gnt_o,
    output logic [3:0]  idx_o,
    output logic        vld_o
);

    logic [3:0] k;

    always_comb begin
        k     = ptr_i;
        idx_o = ptr_i;
        // Scan from the farthest offset back to ptr_i so the nearest
        // requester (smallest wrapped offset) is the last to overwrite idx_o.
        for (int i = 15; i >= 0; i--) begin
            k = ptr_i + 4'(i);
            if (req_i[k]) begin
                idx_o = k;
            end
        end
        vld_o = |req_i;
        gnt_o = vld_o ? (16'(1) << idx_o) : 16'h0000;
    end

endmodule

// File: rtl/port_wr_arbiter.sv
// port_wr_arbiter: per-output-port write arbiter.
// Collects one-cycle request pulses from the channel stages, answers each
// pulse with exactly one resp (grant) or nresp (reject) pulse, forwards the
// granted channel's packet to the cache-write path with one cycle of latency,
// and keeps the free RAM block count that the channel stages use to pick a port.
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_req / o_resp / o_nresp request pulses in, grant / reject pulses out
//   i_sop, i_data, i_data_vld, i_eop   per-channel packet streams
//   o_ready, o_ramspace      port availability and free block count
//   i_rel_vld, i_rel_blocks  blocks released by the read side
//   o_wr_sop/data/vld/eop    forwarded stream, o_wr_src its source channel
//   o_err                    sticky: [0] stray traffic, [1] over-reservation
//   o_dbg                    {PORT_ID, arbiter state} for checkers
//
// Handshake: a channel raises i_req[k] for one cycle; the arbiter answers with
// exactly one single-cycle pulse on o_resp[k] or o_nresp[k]. After o_resp[k]
// the channel owns the port from the next cycle until it presents a word with
// i_eop[k] & i_data_vld[k]; words count only when i_data_vld[k] is high.
module port_wr_arbiter #(
    parameter int                  PORTNUM   = 16,
    parameter int                  DWIDTH    = 32,
    parameter int                  RAMWIDTH  = 11,
    parameter logic [3:0]          PORT_ID   = 4'd0,
    parameter logic [RAMWIDTH-1:0] RAMBLOCKS = 11'd1024
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [PORTNUM-1:0]  i_req,
    output logic [PORTNUM-1:0]  o_resp,
    output logic [PORTNUM-1:0]  o_nresp,
    input  logic [PORTNUM-1:0]  i_sop,
    input  logic [DWIDTH-1:0]   i_data [PORTNUM],
    input  logic [PORTNUM-1:0]  i_data_vld,
    input  logic [PORTNUM-1:0]  i_eop,
    output logic                o_ready,
    output logic [RAMWIDTH-1:0] o_ramspace,
    input  logic                i_rel_vld,
    input  logic [RAMWIDTH-1:0] i_rel_blocks,
    output logic                o_wr_sop,
    output logic [DWIDTH-1:0]   o_wr_data,
    output logic                o_wr_vld,
    output logic                o_wr_eop,
    output logic [3:0]          o_wr_src,
    output logic [1:0]          o_err,
    output logic [5:0]          o_dbg
);

    import mpc_pkg::*;

    arb_state_e           state_q, state_d;
    logic [PORTNUM-1:0]   pending_q, pending_d;
    logic [PORTNUM-1:0]   late_nresp_q, late_nresp_d;
    logic [3:0]           src_q, src_d;
    logic [3:0]           rr_q, rr_d;
    logic [RAMWIDTH-1:0]  free_q, free_d;
    logic [1:0]           err_q, err_d;
    logic                 wr_sop_q, wr_sop_d;
    logic                 wr_vld_q, wr_vld_d;
    logic                 wr_eop_q, wr_eop_d;
    logic [DWIDTH-1:0]    wr_data_q, wr_data_d;

    logic [PORTNUM-1:0]   arb_gnt;
    logic [3:0]           arb_idx;
    logic                 arb_vld;
    logic [PORTNUM-1:0]   resp_now, nresp_now;

    rr_arb16 u_rr (
        .req_i (pending_q),
        .ptr_i (rr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    // Arbiter FSM. Requests arriving in IDLE move straight to GRANT so the
    // winner sees its resp in the cycle after its request pulse.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        src_d        = src_q;
        rr_d         = rr_q;
        late_nresp_d = '0;
        resp_now     = '0;
        nresp_now    = '0;
        case (state_q)
            ARB_IDLE: begin
                pending_d = pending_q | i_req;
                if (pending_d != '0) begin
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                // Losers and anything arriving now are rejected this cycle,
                // so nothing is carried into BUSY.
                resp_now  = arb_gnt;
                nresp_now = (pending_q & ~arb_gnt) | i_req;
                pending_d = '0;
                if (arb_vld) begin
                    src_d = arb_idx;
                    rr_d  = arb_idx + 4'd1;
                end
                state_d = ARB_BUSY;
            end
            ARB_BUSY: begin
                // Requests during a transfer are rejected one cycle later.
                late_nresp_d = i_req;
                if (i_eop[src_q] && i_data_vld[src_q]) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Data path, error flags and free-block accounting.
    logic                  busy;
    logic [PORTNUM-1:0]    src_oh, traffic, stray;
    logic [DWIDTH-1:0]     src_data;
    logic                  hdr;
    logic [HDR_LEN_W:0]    need;
    logic [RAMWIDTH:0]     res_ext, rel_ext, sum, net;

    always_comb begin
        busy     = (state_q == ARB_BUSY);
        src_oh   = PORTNUM'(1) << src_q;
        src_data = i_data[src_q];
        traffic  = i_data_vld | i_sop;
        stray    = busy ? (traffic & ~src_oh) : traffic;

        wr_sop_d  = busy ? i_sop[src_q]      : 1'b0;
        wr_vld_d  = busy ? i_data_vld[src_q] : 1'b0;
        wr_eop_d  = busy ? i_eop[src_q]      : 1'b0;
        wr_data_d = busy ? src_data          : '0;

        hdr     = busy && i_sop[src_q] && i_data_vld[src_q];
        need    = blocks_needed(src_data[HDR_LEN_MSB:HDR_LEN_LSB]);
        res_ext = hdr ? (RAMWIDTH + 1)'(need) : '0;
        rel_ext = i_rel_vld ? {1'b0, i_rel_blocks} : '0;

        // Release and reservation combine as one net update, clamped to
        // [0, RAMBLOCKS].
        sum = {1'b0, free_q} + rel_ext;
        net = (sum < res_ext) ? '0 : (sum - res_ext);
        free_d = (net > {1'b0, RAMBLOCKS}) ? RAMBLOCKS : net[RAMWIDTH-1:0];

        err_d = err_q;
        if (stray != '0) begin
            err_d[0] = 1'b1;
        end
        if (hdr && (res_ext > {1'b0, free_q})) begin
            err_d[1] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ARB_IDLE;
            pending_q    <= '0;
            late_nresp_q <= '0;
            src_q        <= '0;
            rr_q         <= '0;
            free_q       <= RAMBLOCKS;
            err_q        <= '0;
            wr_sop_q     <= 1'b0;
            wr_vld_q     <= 1'b0;
            wr_eop_q     <= 1'b0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            late_nresp_q <= late_nresp_d;
            src_q        <= src_d;
            rr_q         <= rr_d;
            free_q       <= free_d;
            err_q        <= err_d;
            wr_sop_q     <= wr_sop_d;
            wr_vld_q     <= wr_vld_d;
            wr_eop_q     <= wr_eop_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign o_resp     = resp_now;
    assign o_nresp    = nresp_now | late_nresp_q;
    assign o_ready    = (state_q == ARB_IDLE) && (pending_q == '0);
    assign o_ramspace = free_q;
    assign o_wr_sop   = wr_sop_q;
    assign o_wr_data  = wr_data_q;
    assign o_wr_vld   = wr_vld_q;
    assign o_wr_eop   = wr_eop_q;
    assign o_wr_src   = src_q;
    assign o_err      = err_q;
    assign o_dbg      = {PORT_ID, state_q};

endmodule
